// File: rtl/video_pattern_gen.sv
// video_pattern_gen
// Raster timing and RGB test-pattern source for frame-capture and stitching
// benches. One pixel clock, synchronous active-high reset, outputs registered
// (counter state of cycle n is visible on the outputs in cycle n+1).
//
// Ports:
//   clk          pixel clock
//   rst          synchronous active-high reset
//   enable       run request, acted on only at frame boundaries
//   pattern_sel  0 gradient, 1 colour bars, 2 solid, 3 checker (latched per frame)
//   solid_color  colour used by the solid pattern (latched per frame)
//   video_vsync  active-high vertical sync
//   video_hsync  active-high horizontal sync
//   video_de     active-pixel strobe
//   video_data   R[23:16] G[15:8] B[7:0], zero whenever video_de is low
//   frame_cnt    completed-frame count, wraps at 2^16
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | counters held at 0, outputs 0, waiting for enable
// S_RUN  | counters advance every clock; frame end decides RUN or IDLE

module video_pattern_gen #(
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int H_FRONT    = 16,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int V_FRONT    = 10,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    input  logic [23:0]           solid_color,
    output logic                  video_vsync,
    output logic                  video_hsync,
    output logic                  video_de,
    output logic [DATA_WIDTH-1:0] video_data,
    output logic [15:0]           frame_cnt
);

    localparam int H_TOTAL  = H_SYNC + H_BACK + IMG_HDISP + H_FRONT;
    localparam int V_TOTAL  = V_SYNC + V_BACK + IMG_VDISP + V_FRONT;
    localparam int HA_START = H_SYNC + H_BACK;
    localparam int HA_END   = HA_START + IMG_HDISP;
    localparam int VA_START = V_SYNC + V_BACK;
    localparam int VA_END   = VA_START + IMG_VDISP;
    localparam int BAR_W    = IMG_HDISP / 8;
    localparam int BAR_PX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [15:0]           h_cnt_q, h_cnt_d;
    logic [15:0]           v_cnt_q, v_cnt_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [1:0]            pat_q, pat_d;
    logic [23:0]           solid_q, solid_d;
    logic [7:0]            fc_lat_q, fc_lat_d;
    logic [BAR_PX_W-1:0]   bar_px_q, bar_px_d;
    logic [2:0]            bar_idx_q, bar_idx_d;
    logic                  vsync_q, vsync_d;
    logic                  hsync_q, hsync_d;
    logic                  de_q, de_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  h_act, v_act, h_last, v_last;
    logic [7:0]            x_lo, y_lo;
    logic [DATA_WIDTH-1:0] pix;

    assign h_act  = (h_cnt_q >= 16'(HA_START)) && (h_cnt_q < 16'(HA_END));
    assign v_act  = (v_cnt_q >= 16'(VA_START)) && (v_cnt_q < 16'(VA_END));
    assign h_last = (h_cnt_q == 16'(H_TOTAL - 1));
    assign v_last = (v_cnt_q == 16'(V_TOTAL - 1));
    // Only the low byte of each coordinate is ever used, so subtract there.
    assign x_lo   = h_cnt_q[7:0] - 8'(HA_START);
    assign y_lo   = v_cnt_q[7:0] - 8'(VA_START);

    always_comb begin
        pix = '0;
        case (pat_q)
            2'd0: pix = {x_lo, y_lo, fc_lat_q};
            2'd1: begin
                case (bar_idx_q)
                    3'd0:    pix = 24'hFFFFFF;
                    3'd1:    pix = 24'hFFFF00;
                    3'd2:    pix = 24'h00FFFF;
                    3'd3:    pix = 24'h00FF00;
                    3'd4:    pix = 24'hFF00FF;
                    3'd5:    pix = 24'hFF0000;
                    3'd6:    pix = 24'h0000FF;
                    default: pix = 24'h000000;
                endcase
            end
            2'd2:    pix = solid_q;
            default: pix = (x_lo[3] ^ y_lo[3]) ? 24'hFFFFFF : 24'h000000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        pat_d       = pat_q;
        solid_d     = solid_q;
        fc_lat_d    = fc_lat_q;
        bar_px_d    = '0;
        bar_idx_d   = '0;
        vsync_d     = 1'b0;
        hsync_d     = 1'b0;
        de_d        = 1'b0;
        data_d      = '0;

        case (state_q)
            S_IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (enable) state_d = S_RUN;
            end
            default: begin
                // Frame-start snapshot; no active pixel can occur at h_cnt = 0,
                // so the registered copies are ready before they are needed.
                if (h_cnt_q == 16'd0 && v_cnt_q == 16'd0) begin
                    pat_d    = pattern_sel;
                    solid_d  = solid_color;
                    fc_lat_d = frame_cnt_q[7:0];
                end

                if (h_last) begin
                    h_cnt_d = '0;
                    if (v_last) begin
                        v_cnt_d     = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        if (!enable) state_d = S_IDLE;
                    end else begin
                        v_cnt_d = v_cnt_q + 16'd1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 16'd1;
                end

                // Bar sub-counter: cleared outside the active span, so it is at
                // bar 0 / pixel 0 on the first active pixel of every line.
                if (h_act) begin
                    if (bar_px_q == BAR_PX_W'(BAR_W - 1)) begin
                        bar_px_d  = '0;
                        bar_idx_d = bar_idx_q + 3'd1;
                    end else begin
                        bar_px_d  = bar_px_q + 1'b1;
                        bar_idx_d = bar_idx_q;
                    end
                end

                vsync_d = (v_cnt_q < 16'(V_SYNC));
                hsync_d = (h_cnt_q < 16'(H_SYNC));
                de_d    = h_act && v_act;
                data_d  = (h_act && v_act) ? pix : '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            pat_q       <= '0;
            solid_q     <= '0;
            fc_lat_q    <= '0;
            bar_px_q    <= '0;
            bar_idx_q   <= '0;
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            de_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pat_q       <= pat_d;
            solid_q     <= solid_d;
            fc_lat_q    <= fc_lat_d;
            bar_px_q    <= bar_px_d;
            bar_idx_q   <= bar_idx_d;
            vsync_q     <= vsync_d;
            hsync_q     <= hsync_d;
            de_q        <= de_d;
            data_q      <= data_d;
        end
    end

    assign video_vsync = vsync_q;
    assign video_hsync = hsync_q;
    assign video_de    = de_q;
    assign video_data  = data_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Synthesizable video source that produces raster timing (`video_vsync`, `video_hsync`, `video_de`) and 24-bit RGB test-pattern pixels, frame after frame. It sits directly upstream of the frame-capture/BMP-dump sink and of the stitching datapath inputs. It gives the bench a deterministic, parameterizable stream whose captured frames can be checked pixel-exactly.

## Interface
- `IMG_HDISP`, 640: active pixels per line; must be a multiple of 8.
- `IMG_VDISP`, 480: active lines per frame.
- `H_SYNC`, 96: hsync width in clocks.
- `H_BACK`, 48: horizontal back porch in clocks.
- `H_FRONT`, 16: horizontal front porch in clocks.
- `V_SYNC`, 2: vsync width in lines.
- `V_BACK`, 33: vertical back porch in lines.
- `V_FRONT`, 10: vertical front porch in lines.
- `DATA_WIDTH`, 24: pixel width; fixed at 24, packed as R[23:16], G[15:8], B[7:0].
- `clk`, in, 1: pixel clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: run request; sampled only at frame boundaries.
- `pattern_sel`, in, 2: pattern select; latched at frame start.
- `solid_color`, in, 24: colour for solid mode; latched at frame start.
- `video_vsync`, out, 1: active-high vertical sync.
- `video_hsync`, out, 1: active-high horizontal sync.
- `video_de`, out, 1: active-pixel strobe.
- `video_data`, out, DATA_WIDTH: pixel data; 0 whenever `video_de` = 0.
- `frame_cnt`, out, 16: completed-frame count; wraps at 2^16.

## Operation
- H_TOTAL = H_SYNC + H_BACK + IMG_HDISP + H_FRONT; V_TOTAL = V_SYNC + V_BACK + IMG_VDISP + V_FRONT.
- Counters: `h_cnt` runs 0..H_TOTAL-1. `v_cnt` increments when `h_cnt` wraps and runs 0..V_TOTAL-1.
- Line order: sync, back porch, active, front porch. Frame order is the same.
- Decodes:
  - hsync = `h_cnt` < H_SYNC.
  - vsync = `v_cnt` < V_SYNC.
  - de = `h_cnt` in [H_SYNC+H_BACK, H_SYNC+H_BACK+IMG_HDISP) and `v_cnt` in [V_SYNC+V_BACK, V_SYNC+V_BACK+IMG_VDISP).
- Active pixel coordinates: x = `h_cnt` - (H_SYNC+H_BACK); y = `v_cnt` - (V_SYNC+V_BACK).
- FSM states:
  - IDLE: counters held at 0, all outputs 0. If `enable` = 1, go to RUN; the next cycle has `h_cnt` = `v_cnt` = 0.
  - RUN: counters advance every clock. At the last count of the frame (`h_cnt` = H_TOTAL-1, `v_cnt` = V_TOTAL-1), `frame_cnt` increments. Then the FSM stays in RUN with wrapped counters if `enable` = 1, otherwise it goes to IDLE.
- `enable` dropping mid-frame has no effect until the frame ends. Frames are never truncated.
- `pattern_sel` and `solid_color` are latched when RUN begins a frame (`h_cnt` = `v_cnt` = 0), so they are constant for the whole frame.
- Patterns:
  - 0, gradient: R = x[7:0], G = y[7:0], B = `frame_cnt`[7:0], using the value at frame start.
  - 1, colour bars: 8 bars, each IMG_HDISP/8 wide, left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Bar index comes from a sub-counter, not a divider.
  - 2, solid: the latched `solid_color`.
  - 3, checker: FFFFFF when x[3] ^ y[3] = 1, else 000000.

## Timing
- Reset: `video_vsync`, `video_hsync`, `video_de`, `video_data`, `frame_cnt` = 0; FSM in IDLE; counters = 0. Reset overrides everything, including mid-frame.
- Outputs are registered. The counter state in cycle n appears on the outputs in cycle n+1 (latency 1). Sync, de and data are mutually aligned.
- Startup: `enable` high at cycle k while IDLE → RUN with counters 0 at k+1 → `video_vsync` = `video_hsync` = 1 at k+2.
- `frame_cnt` updates on the same edge as the counter wrap, one cycle before the first sync output of the next frame.
- The falling edge of `video_vsync` occurs exactly once per frame. Back-to-back frames have no gap cycles.

## Test plan
Small configuration for all scenarios: IMG_HDISP=8, IMG_VDISP=4, H_SYNC=H_BACK=H_FRONT=2, V_SYNC=V_BACK=V_FRONT=1. This gives H_TOTAL=14, V_TOTAL=7, and a 98-cycle frame.

- Reset then `enable`=1 at cycle 0 → vsync/hsync high at cycle 2; first `video_de` at cycle 34; exactly 32 de cycles per frame; frame period 98 cycles; hsync high 2 of every 14 cycles.
- Gradient, 2 frames → frame 0 first pixel 000000, last pixel 070300; frame 1 first pixel 000001; `frame_cnt` = 2 after two frames.
- Colour bars → each line's 8 pixels are FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; `video_data` = 0 outside de.
- `pattern_sel` changed 2→3 mid-frame with `solid_color`=123456 → that frame stays all 123456; next frame is checker, all 000000 for 8×4 (x[3] = y[3] = 0).
- `enable` dropped mid-frame → frame completes all 32 de cycles, `frame_cnt` increments, outputs then hold 0; re-enable restarts from counters 0.
- `rst` pulsed mid-frame → next cycle all outputs and `frame_cnt` = 0; a clean frame restarts when `enable` = 1.
